// File: rtl/alu_pipe.sv
// Three-stage pipelined ALU with valid/ready handshake on both sides and a
// completed-operation counter; one global advance enable stalls every stage.

package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_AND   = 3'b000,
    OP_OR    = 3'b001,
    OP_ADD   = 3'b010,
    OP_SUB   = 3'b011,
    OP_SLT   = 3'b100,
    OP_SRL1  = 3'b101,
    OP_PASSB = 3'b110,
    OP_ILL   = 3'b111
  } op_e;

endpackage

module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
) (
  input  logic             clkpos,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       flags,
  output logic             eq,
  output logic [CNT_W-1:0] op_count
);

  // Every functional unit's answer is kept so stage 3 only has to select.
  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] and_r;
    logic [WIDTH-1:0] or_r;
    logic [WIDTH-1:0] add_r;
    logic [WIDTH-1:0] sub_r;
    logic [WIDTH-1:0] srl_r;
    logic [WIDTH-1:0] pass_r;
    logic             add_c;
    logic             sub_c;
    logic             add_v;
    logic             sub_v;
    logic             slt;
    logic             eq;
  } s2_t;

  logic adv;

  logic             s1_valid;
  op_e              s1_op;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  logic s2_valid;
  s2_t  s2;
  s2_t  s2_next;

  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;

  logic [WIDTH-1:0] sel_result;
  logic             sel_carry;
  logic             sel_ovf;
  logic             sel_err;
  logic             sel_zero;

  // A full output register that nobody is draining freezes the whole pipe.
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // ---------------------------------------------------------------- stage 1
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours; blocking here would collapse stages.
  always_ff @(posedge clkpos) begin
    if (rst) begin
      s1_valid <= 1'b0;
    end else if (adv) begin
      s1_valid <= in_valid;
    end
  end

  // NOTE: operand/payload registers are deliberately not reset; the valid
  // bit qualifies them, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clkpos) begin
    if (adv && in_valid) begin
      s1_op <= op_e'(op);
      s1_a  <= a;
      s1_b  <= b;
    end
  end

  // ---------------------------------------------------------------- stage 2
  assign add_full = {1'b0, s1_a} + {1'b0, s1_b};
  // Subtraction as a + ~b + 1 so carry-out means "no borrow".
  assign sub_full = {1'b0, s1_a} + {1'b0, ~s1_b} + {{WIDTH{1'b0}}, 1'b1};

  // NOTE: every field gets a default before any branch so always_comb can
  // never hold a previous value, i.e. no latch is inferred.
  always_comb begin
    s2_next        = '0;
    s2_next.op     = s1_op;
    s2_next.and_r  = s1_a & s1_b;
    s2_next.or_r   = s1_a | s1_b;
    s2_next.add_r  = add_full[WIDTH-1:0];
    s2_next.sub_r  = sub_full[WIDTH-1:0];
    s2_next.srl_r  = {1'b0, s1_a[WIDTH-1:1]};
    s2_next.pass_r = s1_b;
    s2_next.add_c  = add_full[WIDTH];
    s2_next.sub_c  = sub_full[WIDTH];
    s2_next.add_v  = (s1_a[WIDTH-1] == s1_b[WIDTH-1]) &&
                     (add_full[WIDTH-1] != s1_a[WIDTH-1]);
    s2_next.sub_v  = (s1_a[WIDTH-1] != s1_b[WIDTH-1]) &&
                     (sub_full[WIDTH-1] != s1_a[WIDTH-1]);
    s2_next.slt    = $signed(s1_a) < $signed(s1_b);
    s2_next.eq     = (s1_a == s1_b);
  end

  always_ff @(posedge clkpos) begin
    if (rst) begin
      s2_valid <= 1'b0;
    end else if (adv) begin
      s2_valid <= s1_valid;
    end
  end

  always_ff @(posedge clkpos) begin
    if (adv && s1_valid) begin
      s2 <= s2_next;
    end
  end

  // ---------------------------------------------------------------- stage 3
  always_comb begin
    sel_result = '0;
    sel_carry  = 1'b0;
    sel_ovf    = 1'b0;
    sel_err    = 1'b0;
    case (s2.op)
      OP_AND:   sel_result = s2.and_r;
      OP_OR:    sel_result = s2.or_r;
      OP_ADD: begin
        sel_result = s2.add_r;
        sel_carry  = s2.add_c;
        sel_ovf    = s2.add_v;
      end
      OP_SUB: begin
        sel_result = s2.sub_r;
        sel_carry  = s2.sub_c;
        sel_ovf    = s2.sub_v;
      end
      OP_SLT:   sel_result = {{(WIDTH-1){1'b0}}, s2.slt};
      OP_SRL1:  sel_result = s2.srl_r;
      OP_PASSB: sel_result = s2.pass_r;
      default:  sel_err    = 1'b1;
    endcase
  end

  // Zero is taken from the selected result, so an illegal op reports zero=1.
  assign sel_zero = (sel_result == '0);

  always_ff @(posedge clkpos) begin
    if (rst) begin
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      eq        <= 1'b0;
    end else if (adv) begin
      out_valid <= s2_valid;
      if (s2_valid) begin
        result <= sel_result;
        flags  <= {sel_err, sel_ovf, sel_carry, sel_zero};
        eq     <= s2.eq;
      end
    end
  end

  always_ff @(posedge clkpos) begin
    if (rst) begin
      op_count <= '0;
    end else if (out_valid && out_ready) begin
      op_count <= op_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe: a 16-bit instance for the main
// function and stall/reset behaviour, an 8-bit/4-bit-counter instance for wrap.

module tb_alu_pipe;

  localparam logic [2:0] C_AND  = 3'b000;
  localparam logic [2:0] C_OR   = 3'b001;
  localparam logic [2:0] C_ADD  = 3'b010;
  localparam logic [2:0] C_SUB  = 3'b011;
  localparam logic [2:0] C_SLT  = 3'b100;
  localparam logic [2:0] C_SRL1 = 3'b101;
  localparam logic [2:0] C_PASS = 3'b110;
  localparam logic [2:0] C_ILL  = 3'b111;

  logic clkpos = 1'b0;
  always #5 clkpos = ~clkpos;

  int checks = 0;
  int passes = 0;

  // 16-bit instance
  logic        rst16 = 1'b1, iv16 = 1'b0, or16 = 1'b1;
  logic        ir16, ov16, eq16;
  logic [2:0]  op16 = '0;
  logic [15:0] a16 = '0, b16 = '0, res16, cnt16;
  logic [3:0]  fl16;

  // 8-bit instance with a 4-bit counter
  logic        rst8 = 1'b1, iv8 = 1'b0, or8 = 1'b1;
  logic        ir8, ov8, eq8;
  logic [2:0]  op8 = '0;
  logic [7:0]  a8 = '0, b8 = '0, res8;
  logic [3:0]  fl8, cnt8;

  alu_pipe #(.WIDTH(16), .CNT_W(16)) dut16 (
    .clkpos(clkpos), .rst(rst16), .in_valid(iv16), .in_ready(ir16),
    .op(op16), .a(a16), .b(b16), .out_valid(ov16), .out_ready(or16),
    .result(res16), .flags(fl16), .eq(eq16), .op_count(cnt16)
  );

  alu_pipe #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clkpos(clkpos), .rst(rst8), .in_valid(iv8), .in_ready(ir8),
    .op(op8), .a(a8), .b(b8), .out_valid(ov8), .out_ready(or8),
    .result(res8), .flags(fl8), .eq(eq8), .op_count(cnt8)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clkpos);
    #1;
  endtask

  // Issue one op, report out_valid after the 2nd and 3rd edge and the
  // outputs at the 3rd, then retire it with out_ready=1.
  task automatic do_op16(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                         output logic early, output logic v, output logic [15:0] r,
                         output logic [3:0] f, output logic e);
    or16 = 1'b1; iv16 = 1'b1; op16 = o; a16 = x; b16 = y;
    tick;
    iv16 = 1'b0;
    tick;
    early = ov16;
    tick;
    v = ov16; r = res16; f = fl16; e = eq16;
    tick;
  endtask

  task automatic do_op8(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y,
                        output logic v, output logic [7:0] r, output logic [3:0] f,
                        output logic e);
    or8 = 1'b1; iv8 = 1'b1; op8 = o; a8 = x; b8 = y;
    tick;
    iv8 = 1'b0;
    tick;
    tick;
    v = ov8; r = res8; f = fl8; e = eq8;
    tick;
  endtask

  task automatic test_reset;
    logic seen;
    rst16 = 1'b1; iv16 = 1'b1; op16 = C_ADD; a16 = 16'h0001; b16 = 16'h0001;
    tick;
    tick;
    checks++; if (ov16 !== 1'b0) $display("FAIL reset_out_valid got %b want 0", ov16); else passes++;
    checks++; if (res16 !== 16'h0) $display("FAIL reset_result got %h want 0000", res16); else passes++;
    checks++; if (fl16 !== 4'h0) $display("FAIL reset_flags got %b want 0000", fl16); else passes++;
    checks++; if (eq16 !== 1'b0) $display("FAIL reset_eq got %b want 0", eq16); else passes++;
    checks++; if (cnt16 !== 16'h0) $display("FAIL reset_op_count got %0d want 0", cnt16); else passes++;
    rst16 = 1'b0; iv16 = 1'b0;
    tick;
    checks++; if (ir16 !== 1'b1) $display("FAIL reset_in_ready got %b want 1", ir16); else passes++;
    seen = 1'b0;
    repeat (4) begin
      if (ov16 !== 1'b0) seen = 1'b1;
      tick;
    end
    checks++; if (seen !== 1'b0) $display("FAIL reset_req_dropped got out_valid %b want 0", seen); else passes++;
  endtask

  task automatic test_ops16;
    logic [2:0]  vop [12];
    logic [15:0] va  [12], vb [12], vr [12];
    logic [3:0]  vf  [12];
    logic        ve  [12];
    logic        early, v, e;
    logic [15:0] r;
    logic [3:0]  f;
    // {err, ovf, carry, zero}
    vop[0]  = C_ADD;  va[0]  = 16'hFFFF; vb[0]  = 16'h0001; vr[0]  = 16'h0000; vf[0]  = 4'b0011; ve[0]  = 1'b0;
    vop[1]  = C_SUB;  va[1]  = 16'h8000; vb[1]  = 16'h0001; vr[1]  = 16'h7FFF; vf[1]  = 4'b0110; ve[1]  = 1'b0;
    vop[2]  = C_SLT;  va[2]  = 16'h8000; vb[2]  = 16'h0001; vr[2]  = 16'h0001; vf[2]  = 4'b0000; ve[2]  = 1'b0;
    vop[3]  = C_AND;  va[3]  = 16'hF0F0; vb[3]  = 16'h3C3C; vr[3]  = 16'h3030; vf[3]  = 4'b0000; ve[3]  = 1'b0;
    vop[4]  = C_OR;   va[4]  = 16'hF0F0; vb[4]  = 16'h0F0F; vr[4]  = 16'hFFFF; vf[4]  = 4'b0000; ve[4]  = 1'b0;
    vop[5]  = C_ADD;  va[5]  = 16'h7FFF; vb[5]  = 16'h0001; vr[5]  = 16'h8000; vf[5]  = 4'b0100; ve[5]  = 1'b0;
    vop[6]  = C_SUB;  va[6]  = 16'h0005; vb[6]  = 16'h0005; vr[6]  = 16'h0000; vf[6]  = 4'b0011; ve[6]  = 1'b1;
    vop[7]  = C_SUB;  va[7]  = 16'h0000; vb[7]  = 16'h0001; vr[7]  = 16'hFFFF; vf[7]  = 4'b0000; ve[7]  = 1'b0;
    vop[8]  = C_SLT;  va[8]  = 16'h0001; vb[8]  = 16'h8000; vr[8]  = 16'h0000; vf[8]  = 4'b0001; ve[8]  = 1'b0;
    vop[9]  = C_SRL1; va[9]  = 16'h8001; vb[9]  = 16'h0000; vr[9]  = 16'h4000; vf[9]  = 4'b0000; ve[9]  = 1'b0;
    vop[10] = C_PASS; va[10] = 16'h1234; vb[10] = 16'h0000; vr[10] = 16'h0000; vf[10] = 4'b0001; ve[10] = 1'b0;
    vop[11] = C_ILL;  va[11] = 16'h0001; vb[11] = 16'h0002; vr[11] = 16'h0000; vf[11] = 4'b1001; ve[11] = 1'b0;
    for (int i = 0; i < 12; i++) begin
      do_op16(vop[i], va[i], vb[i], early, v, r, f, e);
      checks++; if (early !== 1'b0) $display("FAIL op%0d_early_valid got %b want 0", i, early); else passes++;
      checks++; if (v !== 1'b1) $display("FAIL op%0d_latency3_valid got %b want 1", i, v); else passes++;
      checks++; if (r !== vr[i]) $display("FAIL op%0d_result got %h want %h", i, r, vr[i]); else passes++;
      checks++; if (f !== vf[i]) $display("FAIL op%0d_flags got %b want %b", i, f, vf[i]); else passes++;
      checks++; if (e !== ve[i]) $display("FAIL op%0d_eq got %b want %b", i, e, ve[i]); else passes++;
    end
    checks++; if (ov16 !== 1'b0) $display("FAIL ops_drained got out_valid %b want 0", ov16); else passes++;
    checks++; if (cnt16 !== 16'd12) $display("FAIL ops_op_count got %0d want 12", cnt16); else passes++;
  endtask

  task automatic test_back_to_back;
    logic [2:0]  vop [8];
    logic [15:0] va [8], vb [8], vr [8];
    logic [15:0] prev_res;
    logic [3:0]  prev_fl;
    logic        prev_eq, prev_stall;
    int          issued, got;
    vop[0] = C_AND;  va[0] = 16'h00FF; vb[0] = 16'h0F0F; vr[0] = 16'h000F;
    vop[1] = C_OR;   va[1] = 16'h1200; vb[1] = 16'h0034; vr[1] = 16'h1234;
    vop[2] = C_ADD;  va[2] = 16'h0100; vb[2] = 16'h0023; vr[2] = 16'h0123;
    vop[3] = C_SUB;  va[3] = 16'h0050; vb[3] = 16'h0010; vr[3] = 16'h0040;
    vop[4] = C_SLT;  va[4] = 16'hFFFF; vb[4] = 16'h0000; vr[4] = 16'h0001;
    vop[5] = C_SRL1; va[5] = 16'h0246; vb[5] = 16'h0000; vr[5] = 16'h0123;
    vop[6] = C_PASS; va[6] = 16'h0000; vb[6] = 16'hBEEF; vr[6] = 16'hBEEF;
    vop[7] = C_ADD;  va[7] = 16'h7000; vb[7] = 16'h0ABC; vr[7] = 16'h7ABC;
    rst16 = 1'b1; iv16 = 1'b0; or16 = 1'b1;
    tick;
    rst16 = 1'b0;
    issued = 0; got = 0; prev_stall = 1'b0;
    prev_res = '0; prev_fl = '0; prev_eq = 1'b0;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      or16 = !(cyc >= 4 && cyc < 9);
      if (issued < 8) begin
        iv16 = 1'b1; op16 = vop[issued]; a16 = va[issued]; b16 = vb[issued];
      end else begin
        iv16 = 1'b0;
      end
      #1;
      if (ov16 && !or16) begin
        checks++; if (ir16 !== 1'b0) $display("FAIL b2b_stall_in_ready cyc%0d got %b want 0", cyc, ir16); else passes++;
      end
      if (prev_stall) begin
        checks++;
        if (res16 !== prev_res || fl16 !== prev_fl || eq16 !== prev_eq || ov16 !== 1'b1)
          $display("FAIL b2b_frozen cyc%0d got %h/%b/%b want %h/%b/%b", cyc, res16, fl16, eq16, prev_res, prev_fl, prev_eq);
        else passes++;
      end
      if (ov16 && or16) begin
        checks++; if (res16 !== vr[got]) $display("FAIL b2b_result%0d got %h want %h", got, res16, vr[got]); else passes++;
        got++;
      end
      if (iv16 && ir16) issued++;
      prev_stall = ov16 && !or16;
      prev_res = res16; prev_fl = fl16; prev_eq = eq16;
      @(posedge clkpos);
      #1;
    end
    iv16 = 1'b0; or16 = 1'b1;
    checks++; if (got !== 8) $display("FAIL b2b_delivered got %0d want 8", got); else passes++;
    checks++; if (cnt16 !== 16'd8) $display("FAIL b2b_op_count got %0d want 8", cnt16); else passes++;
    tick;
    checks++; if (ov16 !== 1'b0) $display("FAIL b2b_no_extra got out_valid %b want 0", ov16); else passes++;
  endtask

  task automatic test_reset_midflight;
    logic        seen, early, v, e;
    logic [15:0] r;
    logic [3:0]  f;
    rst16 = 1'b1; iv16 = 1'b0; or16 = 1'b1;
    tick;
    rst16 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      iv16 = 1'b1; op16 = C_ADD; a16 = 16'(i); b16 = 16'h0001;
      tick;
    end
    iv16 = 1'b0; rst16 = 1'b1;
    tick;
    rst16 = 1'b0;
    seen = 1'b0;
    repeat (6) begin
      if (ov16 !== 1'b0) seen = 1'b1;
      tick;
    end
    checks++; if (seen !== 1'b0) $display("FAIL midrst_no_valid got %b want 0", seen); else passes++;
    checks++; if (cnt16 !== 16'd0) $display("FAIL midrst_op_count got %0d want 0", cnt16); else passes++;
    do_op16(C_ADD, 16'h0002, 16'h0003, early, v, r, f, e);
    checks++; if (v !== 1'b1 || early !== 1'b0) $display("FAIL midrst_next_latency got %b%b want 01", early, v); else passes++;
    checks++; if (r !== 16'h0005) $display("FAIL midrst_next_result got %h want 0005", r); else passes++;
  endtask

  task automatic test_w8;
    logic       v, e;
    logic [7:0] r;
    logic [3:0] f;
    rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b1;
    tick;
    rst8 = 1'b0;
    do_op8(C_ILL, 8'h55, 8'h55, v, r, f, e);
    checks++; if (v !== 1'b1) $display("FAIL w8_ill_valid got %b want 1", v); else passes++;
    checks++; if (r !== 8'h00) $display("FAIL w8_ill_result got %h want 00", r); else passes++;
    checks++; if (f !== 4'b1001) $display("FAIL w8_ill_flags got %b want 1001", f); else passes++;
    checks++; if (e !== 1'b1) $display("FAIL w8_ill_eq got %b want 1", e); else passes++;
    do_op8(C_SRL1, 8'h81, 8'h00, v, r, f, e);
    checks++; if (r !== 8'h40) $display("FAIL w8_srl1_result got %h want 40", r); else passes++;
    checks++; if (f !== 4'b0000) $display("FAIL w8_srl1_flags got %b want 0000", f); else passes++;
    checks++; if (cnt8 !== 4'd2) $display("FAIL w8_op_count got %0d want 2", cnt8); else passes++;
  endtask

  task automatic test_count_wrap;
    rst8 = 1'b1; iv8 = 1'b0; or8 = 1'b1;
    tick;
    rst8 = 1'b0;
    iv8 = 1'b1; op8 = C_AND; a8 = 8'h0F; b8 = 8'h03;
    repeat (17) tick;
    iv8 = 1'b0;
    repeat (5) tick;
    checks++; if (cnt8 !== 4'd1) $display("FAIL wrap_op_count got %0d want 1", cnt8); else passes++;
    checks++; if (ov8 !== 1'b0) $display("FAIL wrap_drained got out_valid %b want 0", ov8); else passes++;
  endtask

  initial begin
    test_reset;
    test_ops16;
    test_back_to_back;
    test_reset_midflight;
    test_w8;
    test_count_wrap;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
